// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: pops PS/2 scan bytes from a keyboard FIFO and decodes make/break/repeat events.
module ps2_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             kb_ready,
  input  logic [7:0]       kb_data,
  input  logic             kb_overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  output logic             key_repeat,
  output logic             key_release,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, POP, SETTLE, DECODE} state_t;
  state_t state, state_nx;
  logic [7:0] byte_q, held_code;
  logic ext_pend, brk_pend, held_ext;
  logic dec, is_e0, is_f0, is_bad, is_key, match;
  always_comb begin
    state_nx = (state == IDLE) ? ((kb_ready && en) ? POP : IDLE) :
               (state == DECODE) ? IDLE : state_t'(state + 2'd1);
    dec      = state == DECODE;
    is_e0    = byte_q == 8'hE0;
    is_f0    = byte_q == 8'hF0;
    is_bad   = byte_q == 8'h00 || byte_q == 8'hFF;
    is_key   = !(is_e0 || is_f0 || is_bad);
    match    = key_down && {held_ext, held_code} == {ext_pend, byte_q};
  end
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state       <= IDLE;
      nextdata_n  <= 1'b1;
      byte_q      <= '0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
      key_repeat  <= 1'b0;
      key_release <= 1'b0;
      key_down    <= 1'b0;
      press_count <= '0;
      err         <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      held_ext    <= 1'b0;
      held_code   <= '0;
    end else begin
      state       <= state_nx;
      nextdata_n  <= state_nx != POP;
      key_valid   <= dec && is_key && !brk_pend;
      key_repeat  <= dec && is_key && !brk_pend && match;
      key_release <= dec && is_key && brk_pend;
      if (state == IDLE && state_nx == POP) byte_q <= kb_data;
      if (kb_overflow || (dec && is_bad)) err <= 1'b1;
      if (dec) begin
        if (is_e0) ext_pend <= 1'b1;
        else if (is_f0) brk_pend <= 1'b1;
        else begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
          if (is_key) begin
            key_code <= byte_q;
            key_ext  <= ext_pend;
            if (brk_pend) begin
              if (match) key_down <= 1'b0;
            end else if (!match) begin
              held_code   <= byte_q;
              held_ext    <= ext_pend;
              key_down    <= 1'b1;
              press_count <= press_count + 1'b1;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// tb_ps2_scan_ctrl: directed checks of ps2_scan_ctrl against a small keyboard FIFO model.
module tb_ps2_scan_ctrl;
  logic clk = 0, clrn = 0, en = 1, kb_ready = 0, kb_overflow = 0;
  logic [7:0] kb_data = '0, key_code;
  logic nextdata_n, key_ext, key_valid, key_repeat, key_release, key_down, err;
  logic [7:0] press_count;
  int errors = 0, checks = 0, cyc = 0, pops = 0, bad_pop = 0, last_pop = 0;
  logic prev_low = 0;
  logic [7:0] q[$];
  logic [10:0] ev[$];
  int ev_cyc[$];

  ps2_scan_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .en(en), .kb_ready(kb_ready), .kb_data(kb_data),
    .kb_overflow(kb_overflow), .nextdata_n(nextdata_n), .key_code(key_code),
    .key_ext(key_ext), .key_valid(key_valid), .key_repeat(key_repeat),
    .key_release(key_release), .key_down(key_down), .press_count(press_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    kb_ready = q.size() != 0;
    kb_data  = q.size() != 0 ? q[0] : 8'h00;
  endtask

  // The keyboard pops its head while it sees nextdata_n low.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!nextdata_n) begin
      if (prev_low) bad_pop++;
      pops++;
      last_pop = cyc;
      if (q.size() != 0) void'(q.pop_front());
    end
    prev_low = !nextdata_n;
    if (key_valid || key_release) begin
      ev.push_back({key_release, key_repeat, key_ext, key_code});
      ev_cyc.push_back(cyc);
    end
    drive();
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    drive();
  endtask

  task automatic wait_ev(input int n, input int budget);
    int k = 0;
    while (ev.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("ev_timeout", ev.size() >= n, 1);
    repeat (6) tick();
  endtask

  task automatic do_reset();
    clrn = 0;
    tick();
    tick();
    q.delete();
    ev.delete();
    ev_cyc.delete();
    drive();
    pops = 0;
    bad_pop = 0;
    clrn = 1;
    en = 1;
  endtask

  initial begin
    do_reset();
    clrn = 0;
    tick();
    chk("rst_nextdata_n", nextdata_n, 1);
    chk("rst_code", key_code, 0);
    chk("rst_pulses", {key_valid, key_repeat, key_release, key_ext}, 0);
    chk("rst_down", key_down, 0);
    chk("rst_count", press_count, 0);
    chk("rst_err", err, 0);
    clrn = 1;

    push(8'h1C);
    wait_ev(1, 50);
    chk("single_latency", ev_cyc[0] - last_pop, 3);
    chk("single_ev", ev[0], {3'b000, 8'h1C});
    chk("single_code", key_code, 8'h1C);
    chk("single_down", key_down, 1);
    chk("single_count", press_count, 1);
    chk("single_pops", pops, 1);

    do_reset();
    foreach (q[i]) ;
    push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    wait_ev(3, 100);
    chk("rep_ev0", ev[0], {3'b000, 8'h1C});
    chk("rep_ev1", ev[1], {3'b010, 8'h1C});
    chk("rep_ev2", ev[2], {3'b100, 8'h1C});
    chk("rep_count", press_count, 1);
    chk("rep_down", key_down, 0);
    chk("rep_evn", ev.size(), 3);

    do_reset();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    wait_ev(2, 100);
    chk("ext_ev0", ev[0], {3'b001, 8'h75});
    chk("ext_ev1", ev[1], {3'b101, 8'h75});
    chk("ext_evn", ev.size(), 2);
    chk("ext_down", key_down, 0);
    chk("ext_count", press_count, 1);

    do_reset();
    for (int i = 0; i < 256; i++) begin
      push(8'h01 + 8'(i % 127));
      push(8'hF0);
      push(8'h01 + 8'(i % 127));
    end
    wait_ev(512, 4000);
    chk("wrap_count", press_count, 0);
    chk("wrap_evn", ev.size(), 512);
    chk("wrap_pops", pops, 768);
    chk("wrap_no_double_pop", bad_pop, 0);
    chk("wrap_err", err, 0);

    do_reset();
    push(8'hFF);
    repeat (10) tick();
    chk("bad_err", err, 1);
    chk("bad_no_ev", ev.size(), 0);
    repeat (10) tick();
    chk("bad_err_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);
    kb_overflow = 1;
    tick();
    kb_overflow = 0;
    tick();
    chk("ovf_err", err, 1);
    repeat (5) tick();
    chk("ovf_sticky", err, 1);

    do_reset();
    en = 0;
    push(8'h2A);
    repeat (12) tick();
    chk("en_no_pop", pops, 0);
    chk("en_no_ev", ev.size(), 0);
    en = 1;
    wait_ev(1, 50);
    chk("en_resume_ev", ev[0], {3'b000, 8'h2A});

    begin
      int k = 0;
      push(8'h33);
      while (nextdata_n && k < 50) begin
        tick();
        k++;
      end
      chk("settle_pop_seen", nextdata_n, 0);
      tick();
      clrn = 0;
      tick();
      clrn = 1;
      chk("settle_nextdata_n", nextdata_n, 1);
      chk("settle_pulses", {key_valid, key_repeat, key_release, key_ext}, 0);
      chk("settle_code", key_code, 0);
      chk("settle_down", key_down, 0);
      chk("settle_count", press_count, 0);
      repeat (6) tick();
      chk("settle_no_ev", ev.size(), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
